delay_ctrl: RTL
===============

# delay_ctrl

Run-time programmable delay controller for stochastic bitstream lanes. It replaces fixed-depth shift delays wherever the alignment delay between two bitstreams must change without a re-synthesis, for example when retiming operands after a pipeline reconfiguration. A single circular buffer is shared by WIDTH lanes. A config handshake loads a new delay, and a fill state machine keeps the output invalid (zero) until the line holds enough fresh samples for that delay.

## Interface
- WIDTH, 1: number of parallel bitstream lanes.
- MAX_DELAY, 16: buffer depth, which is also the maximum delay. Must be ≥ 2.
- DW, 5: width of the delay value. Must hold MAX_DELAY.
- DEFAULT_DELAY, 1: delay loaded at reset. Range 1..MAX_DELAY.
- CLK  in  1  clock. Reset nRST is synchronous and active-low, on clock CLK.
- nRST  in  1  synchronous active-low reset.
- en  in  1  advance: when high, the line shifts one sample on the rising CLK edge.
- x  in  WIDTH  input bits, one per lane.
- cfg_valid  in  1  request to load a new delay.
- cfg_delay  in  DW  requested delay, in enabled cycles.
- cfg_ready  out  1  config can be accepted this cycle.
- y  out  WIDTH  delayed bits. Forced to 0 while y_valid = 0.
- y_valid  out  1  y carries data delayed by exactly the current delay.

## Operation
- Storage:
  - mem[0..MAX_DELAY-1] holds WIDTH bits per entry.
  - wptr has range 0..MAX_DELAY-1 and points to the next slot to write.
- Enabled edge: mem[wptr] <= x; wptr <= (wptr == MAX_DELAY-1) ? 0 : wptr+1.
- Read address: rd = (wptr − D) mod MAX_DELAY, where D is the current delay.
  - y = y_valid ? mem[rd] : 0, decoded combinationally from registered state.
  - D = MAX_DELAY reads mem[wptr], the oldest entry.
- Delay clamp on accept:
  - cfg_delay = 0 loads 1.
  - cfg_delay > MAX_DELAY loads MAX_DELAY.
  - Otherwise cfg_delay is loaded unchanged.
- States: FILL and RUN. fill_cnt is DW bits wide.
  - FILL: y_valid = 0 and cfg_ready = 0. On an enabled edge:
    - if fill_cnt == D−1, go to RUN;
    - otherwise fill_cnt++.
  - RUN: y_valid = 1 and cfg_ready = 1.
    - cfg_valid && cfg_ready on an edge loads D, sets fill_cnt <= 0 and goes to FILL.
- Simultaneous en and config accept:
  - The sample is written and wptr advances on that edge.
  - That write does not count toward the fill. Counting starts with the next enabled edge.
- cfg_valid while in FILL is ignored. cfg_ready = 0, so the requester must hold cfg_valid.
- en low:
  - mem, wptr and fill_cnt hold.
  - The state does not advance.
  - A config accept in RUN still occurs.
- Reset values:
  - mem all 0, wptr 0, D = DEFAULT_DELAY, fill_cnt 0, state FILL.
  - y = 0, y_valid = 0, cfg_ready = 0.
  - Reset overrides en and cfg_valid on the same edge.

## Timing
- Latency: in RUN, y after the k-th enabled edge equals x sampled at enabled edge k−D+1.
  - With D = 1, y equals the x sampled at the immediately preceding enabled edge. This matches a one-stage register.
- Fill: y_valid rises after D enabled edges counted from the accept or reset edge (exclusive).
  - With en held high, y_valid is high at cycle D after reset release.
- Reconfiguration: y_valid and cfg_ready fall in the cycle immediately after the accept edge.
- Wrap: wptr goes MAX_DELAY−1 → 0 with no bubble. rd wraps modulo MAX_DELAY.
- Reset mid-FILL or mid-RUN: everything returns to reset values on that edge. Any in-progress fill is discarded.

## Test plan
- Reset with en = 1, DEFAULT_DELAY = 1 and x = 1,0,1,1 on consecutive edges:
  - y_valid = 0 before the first edge and 1 after it.
  - y then reads 1,0,1,1, each one cycle after its input edge.
  - cfg_ready = 1 from the first RUN cycle.
- Config with cfg_delay = 16 (MAX_DELAY) and a 40-cycle pseudo-random x:
  - y_valid stays low for 16 enabled cycles.
  - Afterwards y(t) = x(t−15) across two wptr wraps.
- Clamp:
  - cfg_delay = 0 behaves as delay 1.
  - cfg_delay = 31 behaves as delay 16.
  - Fill lengths are 1 and 16 enabled edges respectively.
- en gaps with D = 4 and en toggled 1,0,0,1,1,0,1:
  - y_valid asserts only after the 4th enabled edge.
  - y and wptr hold on every en = 0 cycle.
- Back-to-back config with D = 3:
  - Accept in RUN, then assert cfg_valid again during FILL. The second request is not accepted until cfg_ready returns after 3 enabled edges.
  - Accept coinciding with an en edge: that edge's write is excluded from the fill count.
- Reset mid-fill: nRST = 0 for one edge at fill_cnt = 2 of 5. Afterwards:
  - D = DEFAULT_DELAY, y = 0, y_valid = 0;
  - the fill restarts and memory reads 0.

Source files
------------

// File: rtl/delay_ctrl.sv
// delay_ctrl: run-time programmable bitstream delay line with config handshake and fill tracking
module delay_ctrl #(
    parameter int WIDTH         = 1,
    parameter int MAX_DELAY     = 16,
    parameter int DW            = 5,
    parameter int DEFAULT_DELAY = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    input  logic             cfg_valid,
    input  logic [DW-1:0]    cfg_delay,
    output logic             cfg_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);
    localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    typedef enum logic {FILL, RUN} state_t;

    logic [WIDTH-1:0] mem [MAX_DELAY];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rd;
    logic [DW:0]      rd_sum;
    logic [DW-1:0]    d;
    logic [DW-1:0]    d_new;
    logic [DW-1:0]    fill_cnt;
    logic             accept;
    state_t           state;

    // accept decode, delay clamp and modular read address
    always_comb begin
        accept = (state == RUN) && cfg_valid;
        d_new  = (cfg_delay == '0) ? DW'(1) :
                 (cfg_delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : cfg_delay;
        rd_sum = (DW+1)'(wptr) + (DW+1)'(MAX_DELAY) - (DW+1)'(d);
        rd     = AW'((rd_sum >= (DW+1)'(MAX_DELAY)) ? rd_sum - (DW+1)'(MAX_DELAY) : rd_sum);
    end

    assign y_valid   = (state == RUN);
    assign cfg_ready = (state == RUN);
    assign y         = y_valid ? mem[rd] : '0;

    // circular buffer: write one sample per enabled edge, wrap with no bubble
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < MAX_DELAY; i++) mem[i] <= '0;
            wptr <= '0;
        end else if (en) begin
            mem[wptr] <= x;
            wptr      <= (wptr == AW'(MAX_DELAY - 1)) ? '0 : wptr + AW'(1);
        end
    end

    // fill/run control; the write on an accept edge is not counted toward the fill
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= FILL;
            d        <= DW'(DEFAULT_DELAY);
            fill_cnt <= '0;
        end else if (accept) begin
            state    <= FILL;
            d        <= d_new;
            fill_cnt <= '0;
        end else if (en && state == FILL) begin
            if (fill_cnt == d - DW'(1)) state <= RUN;
            else fill_cnt <= fill_cnt + DW'(1);
        end
    end
endmodule
